// File: rtl/spc_stack_pkg.sv
// -----------------------------------------------------------------------------
// spc_stack_pkg
// Shared CADR sequencer constants used by the subroutine-PC stack:
//   SPC_PTR_W  - SPC stack pointer width (depth = 2**SPC_PTR_W)
//   SPC_DATA_W - SPC stack entry width
//   UPC_W      - micro-PC width
//   SPCW_RETA / SPCW_LBUS - encodings of the push-source select
// -----------------------------------------------------------------------------
package spc_stack_pkg;

  localparam int SPC_PTR_W  = 5;
  localparam int SPC_DATA_W = 19;
  localparam int UPC_W      = 14;

  localparam logic SPCW_RETA = 1'b0;
  localparam logic SPCW_LBUS = 1'b1;

endpackage

// File: rtl/spc_ptr.sv
// -----------------------------------------------------------------------------
// spc_ptr
// Stack pointer of the SPC stack: pointer register, next-pointer logic and
// the write-address/write-enable handed to the storage array.
// Optional macro SPC_DEPTH_TRACK_EN adds an occupancy counter with sticky
// overflow/underflow flags; without it the flags are tied low.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   state_fetch          - commit strobe
//   spcpush, spcpop      - push / pop requests
//   spcptr               - current pointer
//   wr_en, wr_addr       - storage write strobe and address
//   spc_ovf, spc_unf     - sticky overflow / underflow
// -----------------------------------------------------------------------------
module spc_ptr
  import spc_stack_pkg::*;
#(
  parameter int PTR_W = SPC_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_fetch,
  input  logic             spcpush,
  input  logic             spcpop,
  output logic [PTR_W-1:0] spcptr,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic             spc_ovf,
  output logic             spc_unf
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic [PTR_W-1:0] ptr_inc_s;
  logic [PTR_W-1:0] ptr_dec_s;
  logic             push_only_s;
  logic             pop_only_s;
  logic             replace_s;

  assign push_only_s = state_fetch & spcpush & ~spcpop;
  assign pop_only_s  = state_fetch & spcpop & ~spcpush;
  assign replace_s   = state_fetch & spcpush & spcpop;

  // Modulo-depth arithmetic: wrap is silent, no trap.
  assign ptr_inc_s = ptr_r + PTR_W'(1);
  assign ptr_dec_s = ptr_r - PTR_W'(1);

  // Next-pointer selection for the committed operation.
  always_comb begin
    ptr_nxt_s = ptr_r;
    case ({push_only_s, pop_only_s})
      2'b10:   ptr_nxt_s = ptr_inc_s;
      2'b01:   ptr_nxt_s = ptr_dec_s;
      default: ptr_nxt_s = ptr_r;
    endcase
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Push pre-increments; replace overwrites the current top.
  assign wr_en   = push_only_s | replace_s;
  assign wr_addr = replace_s ? ptr_r : ptr_inc_s;
  assign spcptr  = ptr_r;

`ifdef SPC_DEPTH_TRACK_EN
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(2**PTR_W);

  logic [PTR_W:0] occ_r;
  logic           ovf_r;
  logic           unf_r;

  // Occupancy counter saturates at full/empty and raises sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_r <= {(PTR_W+1){1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (push_only_s) begin
      if (occ_r == OCC_FULL) begin
        ovf_r <= 1'b1;
      end else begin
        occ_r <= occ_r + (PTR_W+1)'(1);
      end
    end else if (pop_only_s) begin
      if (occ_r == {(PTR_W+1){1'b0}}) begin
        unf_r <= 1'b1;
      end else begin
        occ_r <= occ_r - (PTR_W+1)'(1);
      end
    end
  end

  assign spc_ovf = ovf_r;
  assign spc_unf = unf_r;
`else
  assign spc_ovf = 1'b0;
  assign spc_unf = 1'b0;
`endif

endmodule

// File: rtl/spc_stack.sv
// -----------------------------------------------------------------------------
// spc_stack
// CADR subroutine-PC stack: 2**PTR_W x DATA_W LIFO feeding the next-PC mux.
// Top-of-stack is read combinationally; all updates commit on clk edges with
// state_fetch high. Optional macro SPC_DEPTH_TRACK_EN enables sticky
// overflow/underflow tracking (in spc_ptr).
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   state_fetch           - commit strobe
//   spcpush, spcpop       - push / pop requests (both = replace top)
//   spcw_sel              - push source: 0 return address (ipc), 1 l bus
//   ipc, l                - push data sources
//   ret_skip              - forces spc1a high
//   spc, spc1a, spcptr    - top entry, modified bit 1, stack pointer
//   spc_ovf, spc_unf      - sticky overflow / underflow
// -----------------------------------------------------------------------------
module spc_stack
  import spc_stack_pkg::*;
#(
  parameter int PTR_W  = SPC_PTR_W,
  parameter int DATA_W = SPC_DATA_W,
  parameter int PC_W   = UPC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_fetch,
  input  logic              spcpush,
  input  logic              spcpop,
  input  logic              spcw_sel,
  input  logic [PC_W-1:0]   ipc,
  input  logic [DATA_W-1:0] l,
  input  logic              ret_skip,
  output logic [DATA_W-1:0] spc,
  output logic              spc1a,
  output logic [PTR_W-1:0]  spcptr,
  output logic              spc_ovf,
  output logic              spc_unf
);

  localparam int DEPTH = 2**PTR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] spcw_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_addr_s;

  spc_ptr #(.PTR_W(PTR_W)) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .state_fetch (state_fetch),
    .spcpush     (spcpush),
    .spcpop      (spcpop),
    .spcptr      (spcptr),
    .wr_en       (wr_en_s),
    .wr_addr     (wr_addr_s),
    .spc_ovf     (spc_ovf),
    .spc_unf     (spc_unf)
  );

  // Return address is zero-extended micro-PC.
  assign spcw_s = (spcw_sel == SPCW_LBUS) ? l : DATA_W'(ipc);

  // Storage array; reset clears every entry so an empty stack reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_addr_s] <= spcw_s;
    end
  end

  assign spc   = mem_r[spcptr];
  assign spc1a = spc[1] | ret_skip;

endmodule
